// File: rtl/dmem_pkg.sv
// dmem_pkg: size encodings, byte-lane mask and misalignment predicate for data_memory_pipe
package dmem_pkg;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;
    localparam logic [1:0] SIZE_D = 2'd3;

    function automatic logic [7:0] lane_mask(input logic [1:0] size, input logic [2:0] off);
        logic [15:0] m;
        m = ((16'd1 << (5'd1 << size)) - 16'd1) << off;
        return m[7:0];
    endfunction

    function automatic logic misaligned(input logic [1:0] size, input logic [2:0] off, input logic wide);
        return ((off & 3'((4'd1 << size) - 4'd1)) != 3'd0) || (size == SIZE_D && !wide);
    endfunction

endpackage

// File: rtl/dmem_load_align.sv
// dmem_load_align: shifts the addressed bytes of a memory word to bit 0 and sign/zero extends them
module dmem_load_align #(
    parameter int XLEN = 64
) (
    input  logic [XLEN-1:0]            i_word,
    input  logic [1:0]                 i_size,
    input  logic [$clog2(XLEN/8)-1:0]  i_off,
    input  logic                       i_unsigned,
    output logic [XLEN-1:0]            o_data
);

    logic [XLEN-1:0] w_sh;
    logic [XLEN-1:0] w_low;
    logic [XLEN-1:0] w_top;
    logic            w_sign;

    assign w_sh   = i_word >> {i_off, 3'b000};
    // a full-width access shifts the 1 out entirely, so the subtraction yields all ones
    assign w_low  = (XLEN'(1) << (7'd8 << i_size)) - XLEN'(1);
    assign w_top  = w_low ^ (w_low >> 1);
    assign w_sign = |(w_sh & w_top);
    assign o_data = (w_sh & w_low) | ((w_sign && !i_unsigned) ? ~w_low : '0);

endmodule

// File: rtl/data_memory_pipe.sv
// data_memory_pipe: pipelined byte-addressable data memory with valid/ready channels and LATENCY-deep response pipe
// Define DMEM_MISALIGN_FAULT_EN to fault misaligned accesses instead of aligning them down.
module data_memory_pipe
    import dmem_pkg::*;
#(
    parameter int XLEN    = 64,
    parameter int DEPTH   = 256,
    parameter int ADDR_W  = 48,
    parameter int LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [XLEN-1:0]   rsp_rdata,
    output logic              rsp_fault
);

    localparam int NB    = XLEN / 8;
    localparam int OFF_W = $clog2(NB);
    localparam int IDX_W = $clog2(DEPTH);

    logic              w_adv;
    logic              w_acc;
    logic              w_we;
    logic              w_fault;
    logic              w_unused;
    logic [1:0]        w_size;
    logic [OFF_W-1:0]  w_off_raw;
    logic [OFF_W-1:0]  w_off;
    logic [IDX_W-1:0]  w_idx;
    logic [7:0]        w_lm8;
    logic [XLEN-1:0]   w_bmask;
    logic [XLEN-1:0]   w_rword;
    logic [XLEN-1:0]   w_wsh;
    logic [XLEN-1:0]   w_merged;
    logic [XLEN-1:0]   w_load;
    logic [XLEN-1:0]   w_words [DEPTH];

    logic [LATENCY-1:0] r_vld;
    logic [LATENCY-1:0] r_fault;
    logic [XLEN-1:0]    r_data [LATENCY];

    assign w_adv     = !rsp_valid || rsp_ready;
    assign req_ready = w_adv && !rst;
    assign w_acc     = req_valid && req_ready;
    assign w_size    = (XLEN == 32 && req_size == SIZE_D) ? SIZE_W : req_size;
    assign w_off_raw = req_addr[OFF_W-1:0];
    assign w_idx     = req_addr[OFF_W +: IDX_W];
    assign w_unused  = ^req_addr[ADDR_W-1:OFF_W+IDX_W];

`ifdef DMEM_MISALIGN_FAULT_EN
    assign w_off   = w_off_raw;
    assign w_fault = misaligned(req_size, 3'(w_off_raw), XLEN == 64);
`else
    assign w_off   = w_off_raw & ~OFF_W'((4'd1 << w_size) - 4'd1);
    assign w_fault = 1'b0;
`endif

    assign w_we     = w_acc && req_write && !w_fault;
    assign w_rword  = w_words[w_idx];
    assign w_lm8    = lane_mask(w_size, 3'(w_off));
    assign w_wsh    = req_wdata << {w_off, 3'b000};
    assign w_merged = (w_rword & ~w_bmask) | (w_wsh & w_bmask);

    always_comb begin
        w_bmask = '0;
        for (int b = 0; b < NB; b++) w_bmask[b*8 +: 8] = {8{w_lm8[b]}};
    end

    // per-word registers carry their power-up value (word i holds i); contents are never reset
    for (genvar i = 0; i < DEPTH; i++) begin : g_mem
        logic [XLEN-1:0] r_word = XLEN'(i);
        always_ff @(posedge clk) begin
            if (w_we && w_idx == IDX_W'(i)) r_word <= w_merged;
        end
        assign w_words[i] = r_word;
    end

    dmem_load_align #(.XLEN(XLEN)) u_align (
        .i_word     (w_rword),
        .i_size     (w_size),
        .i_off      (w_off),
        .i_unsigned (req_unsigned),
        .o_data     (w_load)
    );

    // bubbles carry zero data so the output reads 0 whenever no response is present
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld   <= '0;
            r_fault <= '0;
            for (int k = 0; k < LATENCY; k++) r_data[k] <= '0;
        end else if (w_adv) begin
            r_vld[0]   <= w_acc;
            r_fault[0] <= w_acc && w_fault;
            r_data[0]  <= (w_acc && !req_write && !w_fault) ? w_load : '0;
            for (int k = 1; k < LATENCY; k++) begin
                r_vld[k]   <= r_vld[k-1];
                r_fault[k] <= r_fault[k-1];
                r_data[k]  <= r_data[k-1];
            end
        end
    end

    assign rsp_valid = r_vld[LATENCY-1];
    assign rsp_fault = r_fault[LATENCY-1];
    assign rsp_rdata = r_data[LATENCY-1];

endmodule

// File: tb/tb_data_memory_pipe.sv
// tb_data_memory_pipe: directed checks of data_memory_pipe (XLEN=64, DEPTH=256, LATENCY=3)
module tb_data_memory_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic        req_unsigned = 1'b0;
    logic [47:0] req_addr = '0;
    logic [63:0] req_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [63:0] rsp_rdata;
    logic        rsp_fault;

    int n_tests = 0;
    int n_fail  = 0;

    data_memory_pipe #(.XLEN(64), .DEPTH(256), .ADDR_W(48), .LATENCY(3)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .rsp_fault    (rsp_fault)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic send(input string tag, input logic w, input logic [1:0] sz, input logic u,
                        input logic [47:0] a, input logic [63:0] d);
        int k;
        k = 0;
        req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = u; req_addr = a; req_wdata = d;
        while (!req_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_acc"}, 64'(req_ready), 64'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic get_rsp(input string tag, input logic [63:0] exp_d, input logic exp_f, output int lat);
        int k;
        k = 1;
        while (!rsp_valid && k < 50) begin
            @(negedge clk);
            k++;
        end
        lat = k;
        chk({tag, "_vld"}, 64'(rsp_valid), 64'd1);
        chk({tag, "_dat"}, rsp_rdata, exp_d);
        chk({tag, "_flt"}, 64'(rsp_fault), 64'(exp_f));
    endtask

    task automatic op(input string tag, input logic w, input logic [1:0] sz, input logic u,
                      input logic [47:0] a, input logic [63:0] d, input logic [63:0] exp_d, input logic exp_f);
        int lat;
        send(tag, w, sz, u, a, d);
        get_rsp(tag, exp_d, exp_f, lat);
    endtask

    initial begin
        int lat;
        int seen;
        logic [3:0] pat;
        pat = 4'b1001;

        repeat (3) @(negedge clk);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_rdata", rsp_rdata, 64'd0);
        chk("rst_rsp_fault", 64'(rsp_fault), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", 64'(req_ready), 64'd1);

        op("init_w2", 1'b0, 2'd3, 1'b0, 48'h10, 64'd0, 64'd2, 1'b0);
        op("st_d", 1'b1, 2'd3, 1'b0, 48'h40, 64'h1122334455667788, 64'd0, 1'b0);
        send("ld_d", 1'b0, 2'd3, 1'b0, 48'h40, 64'd0);
        get_rsp("ld_d", 64'h1122334455667788, 1'b0, lat);
        chk("latency", 64'(lat), 64'd3);

        op("st_b", 1'b1, 2'd0, 1'b0, 48'h43, 64'h80, 64'd0, 1'b0);
        op("ld_bs", 1'b0, 2'd0, 1'b0, 48'h43, 64'd0, 64'hFFFFFFFFFFFFFF80, 1'b0);
        op("ld_bu", 1'b0, 2'd0, 1'b1, 48'h43, 64'd0, 64'h80, 1'b0);
        op("ld_d2", 1'b0, 2'd3, 1'b0, 48'h40, 64'd0, 64'h1122334480667788, 1'b0);

`ifdef DMEM_MISALIGN_FAULT_EN
        op("ld_h_mis", 1'b0, 2'd1, 1'b0, 48'h41, 64'd0, 64'd0, 1'b1);
        op("st_h_mis", 1'b1, 2'd1, 1'b0, 48'h45, 64'hBEEF, 64'd0, 1'b1);
        op("ld_d3", 1'b0, 2'd3, 1'b0, 48'h40, 64'd0, 64'h1122334480667788, 1'b0);
        op("ld_wu", 1'b0, 2'd2, 1'b1, 48'h44, 64'd0, 64'h11223344, 1'b0);
`else
        op("ld_h_mis", 1'b0, 2'd1, 1'b0, 48'h41, 64'd0, 64'h7788, 1'b0);
        op("st_h_mis", 1'b1, 2'd1, 1'b0, 48'h45, 64'hBEEF, 64'd0, 1'b0);
        op("ld_d3", 1'b0, 2'd3, 1'b0, 48'h40, 64'd0, 64'h1122BEEF80667788, 1'b0);
        op("ld_wu", 1'b0, 2'd2, 1'b1, 48'h44, 64'd0, 64'h1122BEEF, 1'b0);
`endif
        op("ld_ws", 1'b0, 2'd2, 1'b0, 48'h40, 64'd0, 64'hFFFFFFFF80667788, 1'b0);

        op("w5", 1'b0, 2'd3, 1'b0, 48'h28, 64'd0, 64'd5, 1'b0);
        op("w5_wrap", 1'b0, 2'd3, 1'b0, 48'h28 + 48'd2048, 64'd0, 64'd5, 1'b0);

        fork
            begin
                for (int i = 0; i < 8; i++) send("b2b", 1'b0, 2'd3, 1'b0, 48'h80 + 48'(i * 8), 64'd0);
            end
            begin
                int n;
                int c;
                n = 0;
                c = 0;
                while (n < 8 && c < 200) begin
                    @(posedge clk);
                    #1 rsp_ready = pat[c % 4];
                    @(negedge clk);
                    c++;
                    if (rsp_valid && !rsp_ready) chk("b2b_hold_ready", 64'(req_ready), 64'd0);
                    if (rsp_valid && rsp_ready) begin
                        chk("b2b_data", rsp_rdata, 64'(16 + n));
                        n++;
                    end
                end
                chk("b2b_count", 64'(n), 64'd8);
            end
        join
        rsp_ready = 1'b1;
        seen = 0;
        repeat (5) begin
            @(negedge clk);
            seen |= int'(rsp_valid);
        end
        chk("b2b_extra", 64'(seen), 64'd0);

        send("fl0", 1'b0, 2'd3, 1'b0, 48'h80, 64'd0);
        send("fl1", 1'b0, 2'd3, 1'b0, 48'h88, 64'd0);
        rst = 1'b1;
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'd0; req_addr = 48'h88; req_wdata = 64'h55;
        @(negedge clk);
        chk("rst_flush", 64'(rsp_valid), 64'd0);
        chk("rst_ready_low", 64'(req_ready), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        req_valid = 1'b0;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            seen |= int'(rsp_valid);
        end
        chk("no_stale", 64'(seen), 64'd0);
        op("rst_store_dropped", 1'b0, 2'd3, 1'b0, 48'h88, 64'd0, 64'd17, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/data_memory_pipe.md
# data_memory_pipe

Parametrised, pipelined data memory for the RISC-V core's MEM stage. Successor to the fixed 64-bit single-cycle data memory. Adds byte/half/word/double accesses with sign or zero extension, byte-lane writes, a valid/ready request channel with response backpressure, a configurable read latency, and optional misalignment faults.

## Interface
- XLEN, 64, data word width in bits (32 or 64)
- DEPTH, 256, number of XLEN-bit words (power of two)
- ADDR_W, 48, byte-address width
- LATENCY, 1, cycles from request acceptance to response (1..4)
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  request can be accepted this cycle
- req_write  in  1  1 = store, 0 = load
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = double
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0
- req_addr  in  ADDR_W  byte address
- req_wdata  in  XLEN  store data, right-aligned
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer takes response
- rsp_rdata  out  XLEN  extended load data; 0 for stores and faults
- rsp_fault  out  1  access faulted; no memory side effect

## Operation
- Accept when req_valid && req_ready. Pipeline advance = !rsp_valid || rsp_ready. req_ready = advance && !rst.
- Word index = req_addr[log2(XLEN/8) +: log2(DEPTH)]. Higher address bits are ignored (wrap).
- Byte offset = low log2(XLEN/8) bits. Access bytes = 1 << req_size.
- Store: byte lanes [offset, offset+bytes) are written from req_wdata's low bytes in the acceptance cycle. Other lanes keep their values. A response is still produced (rdata 0, fault 0).
- Load: the word is read in the acceptance cycle. The addressed bytes are shifted to bit 0 and extended to XLEN according to req_unsigned. The result travels through the pipeline.
- A load accepted in any cycle after a store sees that store's data. Same-cycle read-during-write is impossible (one request per cycle).
- req_size = 3 with XLEN = 32 is illegal (see Configuration).
- Memory contents are not reset. At simulation start, word i = i.
- rst: all pipeline valid bits are cleared. In-flight responses are discarded. No request is accepted while rst is high.

## Timing
- Response appears LATENCY cycles after acceptance when rsp_ready stays high. Throughput is 1 request per cycle.
- rsp_ready low with rsp_valid high: the entire pipeline stalls. Output holds stable, req_ready = 0, and no store commits.
- Responses return strictly in request order.
- Reset values: req_ready 0 during rst and 1 after. rsp_valid 0, rsp_rdata 0, rsp_fault 0.

## Configuration
- DMEM_MISALIGN_FAULT_EN defined:
  - A request whose offset is not a multiple of its size, or req_size = 3 with XLEN = 32, responds with rsp_fault = 1 and rdata 0.
  - Faulting stores do not write.
- Undefined:
  - rsp_fault is tied to 0.
  - Low address bits below the access size are forced to 0, so the access is aligned down.
  - req_size = 3 with XLEN = 32 is treated as a word access.

## Structure
- Package dmem_pkg holds:
  - size encodings SIZE_B/SIZE_H/SIZE_W/SIZE_D
  - a function returning the byte-lane mask from size and offset
  - the misalignment predicate
- Sub-module dmem_load_align (combinational): shifts the selected bytes down and sign/zero extends them. Instantiated once, between the memory read and the pipeline.
- The top level holds the memory array, the store lane-merge, and the LATENCY-deep valid/data/fault pipeline.

## Test plan
- Reset, then XLEN=64: store double 0x1122334455667788 at 0x40, load double at 0x40 -> rdata 0x1122334455667788 after exactly LATENCY cycles.
- Store byte 0x80 at 0x43, then load byte signed at 0x43 -> 0xFFFFFFFFFFFFFF80. Load unsigned -> 0x80. Load double at 0x40 -> 0x1122334480667788.
- Back-to-back 8 loads with LATENCY=3 and rsp_ready toggling 1,0,0,1 -> all responses in order, none lost or duplicated. req_ready is low whenever a held response is not taken.
- Load half at 0x41: with DMEM_MISALIGN_FAULT_EN -> rsp_fault 1, rdata 0. Without it -> data from 0x40, fault 0. A misaligned store leaves memory unchanged when the macro is defined.
- Assert rst with 2 responses in flight -> rsp_valid 0 the next cycle, and no stale response appears afterwards. A store presented during rst is not written.
- Fresh simulation, no stores: load double at word 5 (address 0x28) -> rdata 5. Address 0x28 + DEPTH*8 -> also 5 (wrap).
